// File: rtl/rr_burst_arbiter_if.sv
// rtl/rr_burst_arbiter_if.sv - requester/arbiter handshake bundle for rr_burst_arbiter
//
// Purpose : groups the per-requester request/last lines, the downstream beat
//           strobe and the grant outputs of rr_burst_arbiter.
// Signals : req_i[NUM_REQ]   request level per requester
//           last_i[NUM_REQ]  end-of-burst flag per requester (owner's bit used)
//           beat_i           downstream accepted one beat this cycle
//           gnt_o[NUM_REQ]   one-hot grant, zero when idle
//           gnt_id_o         binary owner index, zero when idle
//           busy_o           grant held
//           timeout_o        one-cycle pulse after a MAX_BEATS forced release
// Modports: slave  - the arbiter side
//           master - the requester/downstream side
interface rr_burst_arbiter_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] req_i;
    logic [NUM_REQ-1:0] last_i;
    logic               beat_i;
    logic [NUM_REQ-1:0] gnt_o;
    logic [ID_W-1:0]    gnt_id_o;
    logic               busy_o;
    logic               timeout_o;

    modport slave (
        input  req_i, last_i, beat_i,
        output gnt_o, gnt_id_o, busy_o, timeout_o
    );

    modport master (
        output req_i, last_i, beat_i,
        input  gnt_o, gnt_id_o, busy_o, timeout_o
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - round-robin arbiter granting bursts of up to MAX_BEATS beats
//
// Purpose : hands one downstream resource to one of NUM_REQ requesters at a
//           time. A grant lasts until the owner's last beat, the MAX_BEATS-th
//           beat, or the owner dropping its request; the next owner is picked
//           round-robin starting just after the previous owner.
// Ports   : clk   - rising-edge clock
//           reset - synchronous active-high reset
//           bus   - rr_burst_arbiter_if.slave (req_i, last_i, beat_i in;
//                   gnt_o, gnt_id_o, busy_o, timeout_o out)
module rr_burst_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic                clk,
    input  logic                reset,
    rr_burst_arbiter_if.slave   bus
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t          r_state,   w_state_n;
    logic [ID_W-1:0] r_owner,   w_owner_n;
    logic [ID_W-1:0] r_ptr,     w_ptr_n;
    logic [7:0]      r_cnt,     w_cnt_n;
    logic            r_timeout, w_timeout_n;

    logic [ID_W-1:0] w_rel_ptr;
    logic [ID_W-1:0] w_search_ptr;
    logic [ID_W-1:0] w_win;
    logic            w_found;
    logic            w_last_hit;
    logic            w_max_hit;
    logic            w_abort;
    logic            w_release;

    // Pointer value that takes effect when the current owner lets go.
    assign w_rel_ptr = (r_owner == ID_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

    // On a release cycle the search already uses the updated pointer, so a
    // back-to-back grant needs no extra idle cycle.
    assign w_search_ptr = (r_state == ST_OWNED) ? w_rel_ptr : r_ptr;

    assign w_last_hit = bus.beat_i &  bus.last_i[r_owner];
    assign w_max_hit  = bus.beat_i & (r_cnt == 8'(MAX_BEATS - 1));
    assign w_abort    = ~bus.req_i[r_owner];
    assign w_release  = w_last_hit | w_max_hit | w_abort;

    always_comb begin
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(w_search_ptr) + i) % NUM_REQ;
            if (!w_found && bus.req_i[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_owner_n   = r_owner;
        w_ptr_n     = r_ptr;
        w_cnt_n     = r_cnt;
        w_timeout_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_n = ST_OWNED;
                    w_owner_n = w_win;
                    w_cnt_n   = '0;
                end
            end
            ST_OWNED: begin
                if (w_release) begin
                    w_ptr_n     = w_rel_ptr;
                    // An explicit last beat or an abort is never a timeout.
                    w_timeout_n = w_max_hit & ~w_last_hit & ~w_abort;
                    w_cnt_n     = '0;
                    if (w_found) begin
                        w_owner_n = w_win;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_owner_n = '0;
                    end
                end else if (bus.beat_i && r_cnt != 8'hFF) begin
                    w_cnt_n = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_owner_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_owner   <= w_owner_n;
            r_ptr     <= w_ptr_n;
            r_cnt     <= w_cnt_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign bus.gnt_o     = (r_state == ST_OWNED) ? (NUM_REQ'(1) << r_owner) : '0;
    assign bus.gnt_id_o  = (r_state == ST_OWNED) ? r_owner : '0;
    assign bus.busy_o    = (r_state == ST_OWNED);
    assign bus.timeout_o = r_timeout;
endmodule

// File: doc/rr_burst_arbiter.md
RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing one downstream resource.
REQ-002 Parameter MAX_BEATS, default 8, maximum beats per grant before forced release (2..255).
REQ-003 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on clk.
REQ-005 req_i  input  NUM_REQ  per-requester request level; bit i high = requester i wants the resource.
REQ-006 last_i  input  NUM_REQ  per-requester end-of-burst flag; only the owner's bit is observed.
REQ-007 beat_i  input  1  downstream accepted one beat from the current owner this cycle (valid&ready).
REQ-008 gnt_o  output  NUM_REQ  registered one-hot grant; all-zero when no owner.
REQ-009 gnt_id_o  output  $clog2(NUM_REQ)  binary index of the owner; 0 when gnt_o is zero.
REQ-010 busy_o  output  1  high while a grant is held (equals |gnt_o).
REQ-011 timeout_o  output  1  registered one-cycle pulse when a grant ends by reaching MAX_BEATS.

Function
REQ-012 Two states: IDLE (no owner) and OWNED (one owner, gnt_o one-hot).
REQ-013 IDLE -> OWNED when any req_i bit is high; winner is chosen round-robin and gnt_o is set on the following clk edge (1-cycle request-to-grant latency).
REQ-014 Round-robin order: search starts at priority pointer P and proceeds P, P+1, ..., wrapping modulo NUM_REQ; the first requesting index wins.
REQ-015 P resets to 0; on every grant release P becomes (owner index + 1) mod NUM_REQ in the same edge.
REQ-016 Beat counter: resets to 0 on each new grant, increments by 1 on each cycle beat_i is high while OWNED; it never wraps.
REQ-017 Release conditions, evaluated in OWNED each cycle, any one sufficient: (a) beat_i and last_i[owner]; (b) beat_i and counter == MAX_BEATS-1 (MAX_BEATS-th beat); (c) req_i[owner] low (abort).
REQ-018 timeout_o pulses for the cycle after release only when (b) holds and (a) does not; it is zero on abort.
REQ-019 Back-to-back: on a release cycle, arbitration runs with the updated P on the same-cycle req_i excluding nothing; if any requester (including the previous owner) is requesting, the new grant appears on the next edge with no idle cycle; otherwise state returns to IDLE.
REQ-020 beat_i in IDLE is ignored; last_i of non-owners is ignored; req_i changes of non-owners never affect the current grant.
REQ-021 gnt_o, gnt_id_o and busy_o change only on clk edges and never show more than one grant bit.
REQ-022 Single requester continuously requesting with bursts is re-granted every time, back-to-back.

Reset
REQ-023 reset high: next edge forces state IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, P=0, counter=0.
REQ-024 reset asserted mid-grant aborts the grant without a timeout pulse; first arbitration after reset deassertion starts from index 0.
REQ-025 reset has priority over every other input in the same cycle.

Verification
REQ-026 After reset, req_i=4'b1010 -> next edge gnt_o=4'b0010, gnt_id_o=1, busy_o=1.
REQ-027 Owner 1, req_i held 4'b1111, beat_i with last_i[1] on 3rd beat -> next edge gnt_o=4'b0100 with no idle cycle; continue releasing -> 4'b1000, then 4'b0001 (wrap).
REQ-028 MAX_BEATS=8, owner 0, last_i never high, beat_i every cycle -> grant drops after 8th beat, timeout_o=1 for exactly one cycle, P=1.
REQ-029 Owner 2, req_i[2] drops with no beats -> next edge gnt_o moves to next requester or 0, timeout_o=0, P=3.
REQ-030 Only req_i[3] high, repeated bursts of 2 beats -> gnt_o=4'b1000 continuously, busy_o never drops.
REQ-031 reset pulsed while owner 3 mid-burst at beat 5 -> gnt_o=0 next edge; req_i=4'b1001 after reset -> gnt_o=4'b0001.
